// File: rtl/pe_pkg.sv
// Shared defaults and saturation-limit helpers for the MAC processing element.
package pe_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefWgtW    = 8;
  localparam int unsigned DefAccW    = 20;
  localparam int unsigned DefMultLat = 2;
  localparam int unsigned DefDepth   = 4;

  // Widest accumulator the helpers can describe; callers slice the low bits.
  localparam int unsigned MaxAccW = 64;

  // Largest two's-complement value in w bits: 2^(w-1)-1.
  function automatic logic [MaxAccW-1:0] sat_max_s(input int unsigned w);
    logic [MaxAccW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(MaxAccW); i++) begin
      if (i < int'(w) - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value in w bits: -2^(w-1).
  function automatic logic [MaxAccW-1:0] sat_min_s(input int unsigned w);
    logic [MaxAccW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(MaxAccW); i++) begin
      if (i == int'(w) - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Largest unsigned value in w bits: 2^w-1.
  function automatic logic [MaxAccW-1:0] sat_max_u(input int unsigned w);
    logic [MaxAccW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(MaxAccW); i++) begin
      if (i < int'(w)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Operand multiplier with valid/signed tags carried through MULT_LAT stages.
module mult_pipe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned WGT_W    = DefWgtW,
  parameter int unsigned MULT_LAT = DefMultLat
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iClear,
  input  logic                      iValid,
  input  logic                      iSigned,
  input  logic [DATA_W-1:0]         iData,
  input  logic [WGT_W-1:0]          iWeight,
  output logic                      oValid,
  output logic                      oSigned,
  output logic [DATA_W+WGT_W-1:0]   oProd
);

  localparam int unsigned ProdW = DATA_W + WGT_W;

  logic [ProdW-1:0]    w_a;
  logic [ProdW-1:0]    w_b;
  logic [ProdW-1:0]    w_prod;

  logic [MULT_LAT-1:0] r_vld;
  logic [MULT_LAT-1:0] r_sgn;
  logic [ProdW-1:0]    r_prod [MULT_LAT];

  // Extend both operands to the full product width; the low ProdW bits of the
  // modular product are then correct for both signed and unsigned operands.
  always_comb begin
    w_a    = {{WGT_W{iSigned & iData[DATA_W-1]}}, iData};
    w_b    = {{DATA_W{iSigned & iWeight[WGT_W-1]}}, iWeight};
    w_prod = w_a * w_b;
  end

  // Product/tag shift register; a clear kills every in-flight tag and the
  // pair offered in the same cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_vld <= '0;
      r_sgn <= '0;
      for (int i = 0; i < int'(MULT_LAT); i++) r_prod[i] <= '0;
    end else begin
      r_vld[0]  <= iValid & ~iClear;
      r_sgn[0]  <= iSigned;
      r_prod[0] <= w_prod;
      for (int i = 1; i < int'(MULT_LAT); i++) begin
        r_vld[i]  <= r_vld[i-1] & ~iClear;
        r_sgn[i]  <= r_sgn[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign oValid  = r_vld[MULT_LAT-1];
  assign oSigned = r_sgn[MULT_LAT-1];
  assign oProd   = r_prod[MULT_LAT-1];

endmodule

// File: rtl/pe_mac_win.sv
// Systolic PE: forwards operands and accumulates DEPTH products per window
// with saturation, reporting each completed window as a one-cycle pulse.
module pe_mac_win
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned WGT_W    = DefWgtW,
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned MULT_LAT = DefMultLat,
  parameter int unsigned DEPTH    = DefDepth
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  input  logic [WGT_W-1:0]  iWeight,
  input  logic              iSigned,
  input  logic              iClearAcc,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic [WGT_W-1:0]  oWeight,
  output logic [ACC_W-1:0]  oAcc,
  output logic              oAccValid,
  output logic              oSat
);

  localparam int unsigned ProdW = DATA_W + WGT_W;
  localparam int unsigned CntW  = $clog2(DEPTH);

  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  localparam logic [MaxAccW-1:0] SMaxFull = sat_max_s(ACC_W);
  localparam logic [MaxAccW-1:0] SMinFull = sat_min_s(ACC_W);
  localparam logic [MaxAccW-1:0] UMaxFull = sat_max_u(ACC_W);
  localparam logic [ACC_W-1:0]   SMax     = SMaxFull[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   SMin     = SMinFull[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   UMax     = UMaxFull[ACC_W-1:0];

  if (ACC_W < DATA_W + WGT_W) begin : g_bad_acc_w
    $error("pe_mac_win: ACC_W must be at least DATA_W+WGT_W");
  end
  if (ACC_W > MaxAccW) begin : g_wide_acc_w
    $error("pe_mac_win: ACC_W exceeds helper width");
  end
  if (MULT_LAT < 1 || MULT_LAT > 4) begin : g_bad_lat
    $error("pe_mac_win: MULT_LAT must be in 1..4");
  end
  if (DEPTH < 2 || DEPTH > 65535) begin : g_bad_depth
    $error("pe_mac_win: DEPTH must be in 2..65535");
  end

  logic             w_pvld;
  logic             w_psgn;
  logic [ProdW-1:0] w_prod;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum_s;
  logic [ACC_W:0]   w_sum_u;
  logic [ACC_W-1:0] w_add_res;
  logic             w_add_sat;

  logic [DATA_W-1:0] r_data;
  logic [WGT_W-1:0]  r_weight;
  logic              r_valid;
  logic [ACC_W-1:0]  r_acc;
  logic [CntW-1:0]   r_cnt;
  logic              r_sat;
  logic [ACC_W-1:0]  r_acc_out;
  logic              r_acc_valid;
  logic              r_sat_out;

  mult_pipe #(
    .DATA_W   (DATA_W),
    .WGT_W    (WGT_W),
    .MULT_LAT (MULT_LAT)
  ) u_mult_pipe (
    .iClk    (iClk),
    .iRst    (iRst),
    .iClear  (iClearAcc),
    .iValid  (iValid),
    .iSigned (iSigned),
    .iData   (iData),
    .iWeight (iWeight),
    .oValid  (w_pvld),
    .oSigned (w_psgn),
    .oProd   (w_prod)
  );

  // Saturating add of the extended product; range follows this product's tag.
  always_comb begin
    if (w_psgn) w_ext = ACC_W'($signed(w_prod));
    else        w_ext = ACC_W'(w_prod);
    w_sum_s   = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
    w_sum_u   = {1'b0, r_acc} + {1'b0, w_ext};
    w_add_res = w_sum_u[ACC_W-1:0];
    w_add_sat = 1'b0;
    if (w_psgn) begin
      w_add_res = w_sum_s[ACC_W-1:0];
      if (w_sum_s[ACC_W] != w_sum_s[ACC_W-1]) begin
        w_add_sat = 1'b1;
        w_add_res = w_sum_s[ACC_W] ? SMin : SMax;
      end
    end else if (w_sum_u[ACC_W]) begin
      w_add_sat = 1'b1;
      w_add_res = UMax;
    end
  end

  // Unconditional one-cycle operand forwarding to neighbouring PEs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_weight <= '0;
    end else begin
      r_valid  <= iValid;
      r_data   <= iData;
      r_weight <= iWeight;
    end
  end

  // Window accumulator: the last product of a window publishes the result and
  // restarts the window in the same edge so the next product is not dropped.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
      r_sat_out   <= 1'b0;
    end else begin
      r_acc_valid <= 1'b0;
      if (iClearAcc) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_pvld) begin
        if (r_cnt == LastCnt) begin
          r_acc_out   <= w_add_res;
          r_sat_out   <= r_sat | w_add_sat;
          r_acc_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_sat       <= 1'b0;
        end else begin
          r_acc <= w_add_res;
          r_cnt <= r_cnt + CntW'(1);
          r_sat <= r_sat | w_add_sat;
        end
      end
    end
  end

  assign oValid    = r_valid;
  assign oData     = r_data;
  assign oWeight   = r_weight;
  assign oAcc      = r_acc_out;
  assign oAccValid = r_acc_valid;
  assign oSat      = r_sat_out;

endmodule

// File: tb/tb_pe_mac_win.sv
// Directed bench for pe_mac_win: default instance plus a 16-bit accumulator
// instance sharing the same stimulus for the saturation case.
module tb_pe_mac_win;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iValid;
  logic [7:0] iData;
  logic [7:0] iWeight;
  logic       iSigned;
  logic       iClearAcc;

  logic        oValid, oAccValid, oSat;
  logic [7:0]  oData, oWeight;
  logic [19:0] oAcc;

  logic        v16, av16, sat16;
  logic [7:0]  d16, w16;
  logic [15:0] acc16;

  int n_err = 0;
  int n_chk = 0;

  int          n_pulse = 0;
  logic [19:0] res_acc [32];
  logic        res_sat [32];
  int          n_pulse16 = 0;
  logic [15:0] res_acc16 [32];
  logic        res_sat16 [32];

  int p0;

  always #5 iClk = ~iClk;

  pe_mac_win dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iData     (iData),
    .iWeight   (iWeight),
    .iSigned   (iSigned),
    .iClearAcc (iClearAcc),
    .oValid    (oValid),
    .oData     (oData),
    .oWeight   (oWeight),
    .oAcc      (oAcc),
    .oAccValid (oAccValid),
    .oSat      (oSat)
  );

  pe_mac_win #(.ACC_W(16)) dut16 (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iData     (iData),
    .iWeight   (iWeight),
    .iSigned   (iSigned),
    .iClearAcc (iClearAcc),
    .oValid    (v16),
    .oData     (d16),
    .oWeight   (w16),
    .oAcc      (acc16),
    .oAccValid (av16),
    .oSat      (sat16)
  );

  // Record every window result, sampled mid-cycle.
  always @(negedge iClk) begin
    if (oAccValid) begin
      res_acc[n_pulse % 32] <= oAcc;
      res_sat[n_pulse % 32] <= oSat;
      n_pulse <= n_pulse + 1;
    end
    if (av16) begin
      res_acc16[n_pulse16 % 32] <= acc16;
      res_sat16[n_pulse16 % 32] <= sat16;
      n_pulse16 <= n_pulse16 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] w, input logic s);
    iValid  = 1'b1;
    iData   = d;
    iWeight = w;
    iSigned = s;
    tick();
  endtask

  task automatic idle(input int n);
    iValid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live operands on the inputs: outputs must still read zero.
    iRst = 1'b1; iValid = 1'b1; iData = 8'h55; iWeight = 8'h33;
    iSigned = 1'b0; iClearAcc = 1'b0;
    repeat (3) tick();
    chk("rst_oValid",    64'(oValid),    64'd0);
    chk("rst_oData",     64'(oData),     64'd0);
    chk("rst_oWeight",   64'(oWeight),   64'd0);
    chk("rst_oAcc",      64'(oAcc),      64'd0);
    chk("rst_oAccValid", 64'(oAccValid), 64'd0);
    chk("rst_oSat",      64'(oSat),      64'd0);
    iRst = 1'b0;
    idle(1);

    // Unsigned window: 15+14+100+1 = 130; pulse two edges after the last pair.
    send(8'd3, 8'd5, 1'b0);
    send(8'd2, 8'd7, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    idle(1);
    chk("u_pulse_early", 64'(oAccValid), 64'd0);
    tick();
    chk("u_pulse",       64'(oAccValid), 64'd1);
    chk("u_acc",         64'(oAcc),      64'd130);
    chk("u_sat",         64'(oSat),      64'd0);
    tick();
    chk("u_pulse_width", 64'(oAccValid), 64'd0);
    chk("u_acc_hold",    64'(oAcc),      64'd130);

    // Two back-to-back signed windows: 4*16384 = 65536, 4*(-16256) = -65024.
    p0 = n_pulse;
    repeat (4) send(8'h80, 8'h80, 1'b1);
    repeat (4) send(8'h7F, 8'h80, 1'b1);
    idle(4);
    chk("s_pulses", 64'(n_pulse - p0),        64'd2);
    chk("s_acc0",   64'(res_acc[p0 % 32]),     64'h10000);
    chk("s_sat0",   64'(res_sat[p0 % 32]),     64'd0);
    chk("s_acc1",   64'(res_acc[(p0+1) % 32]), 64'hF0200);  // -65024 in 20 bits
    chk("s_sat1",   64'(res_sat[(p0+1) % 32]), 64'd0);

    // Unsigned saturation on the 16-bit instance, then a clean window.
    p0 = n_pulse16;
    repeat (4) send(8'd255, 8'd255, 1'b0);
    repeat (4) send(8'd1, 8'd1, 1'b0);
    idle(4);
    chk("sat_pulses", 64'(n_pulse16 - p0),          64'd2);
    chk("sat_acc0",   64'(res_acc16[p0 % 32]),       64'hFFFF);
    chk("sat_flag0",  64'(res_sat16[p0 % 32]),       64'd1);
    chk("sat_acc1",   64'(res_acc16[(p0+1) % 32]),   64'd4);
    chk("sat_flag1",  64'(res_sat16[(p0+1) % 32]),   64'd0);

    // Partial window, gap, abort (pair offered with the clear is dropped).
    p0 = n_pulse;
    send(8'd5, 8'd5, 1'b0);
    send(8'd5, 8'd5, 1'b0);
    idle(3);
    iClearAcc = 1'b1; iValid = 1'b1; iData = 8'd100; iWeight = 8'd100; iSigned = 1'b0;
    tick();
    iClearAcc = 1'b0;
    chk("clr_no_pulse", 64'(oAccValid), 64'd0);
    repeat (4) send(8'd1, 8'd1, 1'b0);
    idle(4);
    chk("clr_pulses", 64'(n_pulse - p0),    64'd1);
    chk("clr_acc",    64'(res_acc[p0 % 32]), 64'd4);
    chk("clr_sat",    64'(res_sat[p0 % 32]), 64'd0);

    // Reset with two products in flight; forwarding tracked throughout.
    send(8'd2, 8'd3, 1'b0);
    chk("fwd_data_a", 64'(oData),   64'd2);
    send(8'd2, 8'd3, 1'b0);
    chk("fwd_wgt_a",  64'(oWeight), 64'd3);
    iRst = 1'b1; iData = 8'd9; iWeight = 8'd9;
    tick();
    chk("mrst_oValid",    64'(oValid),    64'd0);
    chk("mrst_oData",     64'(oData),     64'd0);
    chk("mrst_oWeight",   64'(oWeight),   64'd0);
    chk("mrst_oAcc",      64'(oAcc),      64'd0);
    chk("mrst_oAccValid", 64'(oAccValid), 64'd0);
    chk("mrst_oSat",      64'(oSat),      64'd0);
    iRst = 1'b0;
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      send(8'(4 + i), 8'd5, 1'b0);
      chk("fwd_valid", 64'(oValid),  64'd1);
      chk("fwd_data",  64'(oData),   64'(4 + i));
      chk("fwd_wgt",   64'(oWeight), 64'd5);
    end
    idle(1);
    chk("fwd_idle", 64'(oValid), 64'd0);
    idle(3);
    // 5*(4+5+6+7) = 110
    chk("mrst_pulses", 64'(n_pulse - p0),    64'd1);
    chk("mrst_acc",    64'(res_acc[p0 % 32]), 64'd110);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_mac_win.md
PE_MAC_WIN -- requirements
Module: pe_mac_win

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data operand width.
REQ-002 SHALL have parameter WGT_W, default 8, weight operand width.
REQ-003 SHALL have parameter ACC_W, default 20, accumulator and result width; elaboration error if ACC_W < DATA_W+WGT_W.
REQ-004 SHALL have parameter MULT_LAT, default 2, multiplier pipeline depth; legal range 1..4.
REQ-005 SHALL have parameter DEPTH, default 4, number of valid products per accumulation window; legal range 2..65535.
REQ-006 SHALL have port iClk  in  1  clock; all logic rising-edge.
REQ-007 SHALL have port iRst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port iValid  in  1  operand pair valid.
REQ-009 SHALL have ports iData  in  DATA_W and iWeight  in  WGT_W, the operands.
REQ-010 SHALL have port iSigned  in  1  1 = two's-complement operands, 0 = unsigned; sampled with iValid.
REQ-011 SHALL have port iClearAcc  in  1  abort the current window.
REQ-012 SHALL have ports oValid  out  1, oData  out  DATA_W and oWeight  out  WGT_W: forwarded operands for the neighbouring PEs.
REQ-013 SHALL have port oAcc  out  ACC_W  completed window result.
REQ-014 SHALL have port oAccValid  out  1  one-cycle pulse, oAcc updated this cycle.
REQ-015 SHALL have port oSat  out  1  saturation occurred in the reported window; valid with oAccValid.

Function
REQ-016 SHALL register oValid/oData/oWeight from iValid/iData/iWeight every cycle: 1-cycle latency, unconditional, no gating.
REQ-017 SHALL form the product of iData and iWeight (signedness per iSigned) in the same cycle the operands are sampled; it SHALL carry a valid tag and a signed tag through exactly MULT_LAT pipeline stages.
REQ-018 SHALL extend the product to ACC_W: sign-extend if its tag is signed, else zero-extend.
REQ-019 On a tagged-valid product, SHALL add it to the internal accumulator with saturation: signed clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned clamps to 2^ACC_W-1.
REQ-020 Any clamp SHALL set the internal sticky sat flag.
REQ-021 SHALL count valid products with counter cnt, 0..DEPTH-1; invalid pipeline slots SHALL NOT advance cnt or the accumulator.
REQ-022 On the valid product that makes cnt = DEPTH-1: oAcc <= saturated final sum; oSat <= sat flag including this add; oAccValid = 1 for one cycle; accumulator, cnt and sat flag SHALL clear in the same cycle.
REQ-023 The next window SHALL start accumulating on the very next valid product with no bubble (back-to-back windows at full rate).
REQ-024 oAcc and oSat SHALL hold their values between pulses.
REQ-025 iClearAcc SHALL clear the accumulator, cnt, sat flag and all in-flight valid tags on the next edge, with priority over a simultaneous product; no oAccValid pulse is produced for an aborted window; oAcc is unchanged.
REQ-026 An operand pair sampled in the same cycle as iClearAcc SHALL be discarded; pairs from the following cycle onward SHALL be accepted.
REQ-027 Mixed iSigned within one window is legal; each product SHALL be interpreted per its own tag, and the saturation range SHALL follow the tag of the current product.

Reset
REQ-028 iRst SHALL clear oValid, oData, oWeight, oAcc, oAccValid, oSat, the accumulator, cnt, the sat flag and all pipeline valid tags to 0 on the next edge, with priority over all other inputs.
REQ-029 Reset mid-window SHALL discard the partial sum and in-flight products; no oAccValid SHALL be produced until DEPTH new valid products complete.

Structure
REQ-030 Package pe_pkg SHALL hold the default width/latency/depth constants and the saturation-limit helper functions.
REQ-031 Multiplication and tag pipelining SHALL be in one sub-module, mult_pipe, parameterised by DATA_W, WGT_W and MULT_LAT.

Verification (defaults; DEPTH=4, MULT_LAT=2)
REQ-032 Unsigned: 4 back-to-back pairs (3,5),(2,7),(10,10),(1,1) -> oAccValid pulses 1 cycle after the last pair's product exits the pipe; oAcc=130, oSat=0.
REQ-033 Signed: pairs (-128,-128)x4 -> oAcc=65536, oSat=0; then (127,-128)x4 -> oAcc=-65024, oSat=0.
REQ-034 Saturation with ACC_W=16, unsigned: (255,255)x4 -> oAcc=65535, oSat=1; next clean window -> oSat=0.
REQ-035 Gaps and clear: 2 valid pairs, 3 idle cycles, iClearAcc, then 4 pairs of (1,1) -> exactly one pulse, oAcc=4.
REQ-036 iRst asserted while 2 products are in flight -> all outputs 0 next cycle; no pulse until 4 new valid products complete; oData/oWeight track the inputs with 1-cycle delay throughout.
